// File: rtl/clk_divider_multi_pkg.sv
// ---------------------------------------------------------------------------
// clk_divider_multi_pkg
// Shared constants and helpers for the multi-channel clock divider.
//   NCH_DEF / CNT_W_DEF     : default channel count and counter width
//   DEF_DIV_RST / DEF_HIGH_RST : period / high time loaded by reset
//   ch_width()              : channel-select width, never below 1 bit
//   cfg_legal()             : legality check for a (div, high) request
// ---------------------------------------------------------------------------
package clk_divider_multi_pkg;

    localparam int NCH_DEF      = 4;
    localparam int CNT_W_DEF    = 8;
    localparam int DEF_DIV_RST  = 12;
    localparam int DEF_HIGH_RST = 6;

    // Width of the channel select; a single channel still gets a 1-bit select.
    function automatic int ch_width(input int nch);
        if (nch > 1) begin
            return $clog2(nch);
        end else begin
            return 1;
        end
    endfunction

    // A period needs at least two cycles and the high time must leave at
    // least one low cycle, otherwise the output would never toggle.
    function automatic logic cfg_legal(input logic [31:0] div, input logic [31:0] high);
        return (div >= 32'd2) && (high >= 32'd1) && (high < div);
    endfunction

endpackage

// File: rtl/clk_divider_chan.sv
// ---------------------------------------------------------------------------
// clk_divider_chan
// One divider channel: phase counter, active and shadow configuration,
// pending flag, registered divided clock and wrap tick.
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   en                : run enable (low forces counter and outputs to zero)
//   sync              : restart the period at the next edge
//   cfg_we            : write cfg_div/cfg_high to the shadow (already legal)
//   cfg_div, cfg_high : new period / high time
//   pend              : shadow holds an unapplied configuration
//   clk_out, tick     : registered divided clock and last-cycle strobe
// ---------------------------------------------------------------------------
module clk_divider_chan
    import clk_divider_multi_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_DIV  = DEF_DIV_RST,
    parameter int DEF_HIGH = DEF_HIGH_RST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             pend,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] act_div_r;
    logic [CNT_W-1:0] act_high_r;
    logic [CNT_W-1:0] shd_div_r;
    logic [CNT_W-1:0] shd_high_r;
    logic             pend_r;
    logic             clk_out_r;
    logic             tick_r;

    logic [CNT_W-1:0] cnt_n_s;
    logic [CNT_W-1:0] act_div_n_s;
    logic [CNT_W-1:0] act_high_n_s;
    logic             apply_s;
    logic             wrap_s;
    logic             hi_n_s;
    logic             tick_n_s;

    // Next-state counter/config; the shadow only reaches the active set at a
    // period boundary (wrap, sync or disable), so a period is never cut short.
    always_comb begin
        cnt_n_s      = cnt_r;
        apply_s      = 1'b0;
        act_div_n_s  = act_div_r;
        act_high_n_s = act_high_r;
        wrap_s       = (cnt_r == (act_div_r - ONE));

        if (!en) begin
            cnt_n_s = ZERO;
            apply_s = pend_r;
        end else if (sync) begin
            cnt_n_s = ZERO;
            apply_s = pend_r;
        end else if (wrap_s) begin
            cnt_n_s = ZERO;
            apply_s = pend_r;
        end else begin
            cnt_n_s = cnt_r + ONE;
            apply_s = 1'b0;
        end

        if (apply_s) begin
            act_div_n_s  = shd_div_r;
            act_high_n_s = shd_high_r;
        end else begin
            act_div_n_s  = act_div_r;
            act_high_n_s = act_high_r;
        end

        // Outputs are decoded from next state so the flops line up with cnt.
        hi_n_s   = en && (cnt_n_s >= (act_div_n_s - act_high_n_s));
        tick_n_s = en && (cnt_n_s == (act_div_n_s - ONE));
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= ZERO;
            act_div_r  <= RST_DIV;
            act_high_r <= RST_HIGH;
            shd_div_r  <= RST_DIV;
            shd_high_r <= RST_HIGH;
            pend_r     <= 1'b0;
            clk_out_r  <= 1'b0;
            tick_r     <= 1'b0;
        end else begin
            cnt_r      <= cnt_n_s;
            act_div_r  <= act_div_n_s;
            act_high_r <= act_high_n_s;
            // A write only happens while pend is clear, so it never collides
            // with an apply; the new value waits for the following boundary.
            if (cfg_we) begin
                shd_div_r  <= cfg_div;
                shd_high_r <= cfg_high;
                pend_r     <= 1'b1;
            end else if (apply_s) begin
                shd_div_r  <= shd_div_r;
                shd_high_r <= shd_high_r;
                pend_r     <= 1'b0;
            end else begin
                shd_div_r  <= shd_div_r;
                shd_high_r <= shd_high_r;
                pend_r     <= pend_r;
            end
            clk_out_r  <= hi_n_s;
            tick_r     <= tick_n_s;
        end
    end

    assign pend    = pend_r;
    assign clk_out = clk_out_r;
    assign tick    = tick_r;

endmodule

// File: rtl/clk_divider_multi.sv
// ---------------------------------------------------------------------------
// clk_divider_multi
// NCH independent programmable clock dividers sharing one config port.
// Ports:
//   clk, reset         : system clock, synchronous active-high reset
//   en[NCH]            : per-channel run enable
//   sync               : restart all enabled channels at the next edge
//   cfg_valid/ready    : config handshake (ready = target shadow is free)
//   cfg_chan/div/high  : target channel, new period, new high time
//   cfg_err            : one-cycle pulse after an accepted illegal request
//   clk_out[NCH]       : registered divided clocks
//   tick[NCH]          : registered strobe on the last cycle of each period
// ---------------------------------------------------------------------------
module clk_divider_multi
    import clk_divider_multi_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_DIV  = DEF_DIV_RST,
    parameter int DEF_HIGH = DEF_HIGH_RST,
    // Derived from NCH; not meant to be overridden.
    parameter int CH_W     = ch_width(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_chan,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    logic [NCH-1:0] pend_s;
    logic [NCH-1:0] cfg_we_s;
    logic           chan_ok_s;
    logic           legal_s;
    logic           accept_s;
    logic           cfg_err_r;

    assign chan_ok_s = (32'(cfg_chan) < 32'(NCH));
    assign legal_s   = chan_ok_s && cfg_legal(32'(cfg_div), 32'(cfg_high));
    assign accept_s  = cfg_valid && cfg_ready;

    // Ready mux: an out-of-range channel is always "ready" so the request is
    // consumed and reported through cfg_err instead of stalling the master.
    always_comb begin
        if (chan_ok_s) begin
            cfg_ready = !pend_s[cfg_chan];
        end else begin
            cfg_ready = 1'b1;
        end
    end

    // Rejection strobe, one cycle after the offending request.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= accept_s && !legal_s;
        end
    end

    assign cfg_err = cfg_err_r;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign cfg_we_s[i] = accept_s && legal_s && (32'(cfg_chan) == 32'(i));

        clk_divider_chan #(
            .CNT_W    (CNT_W),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .en       (en[i]),
            .sync     (sync),
            .cfg_we   (cfg_we_s[i]),
            .cfg_div  (cfg_div),
            .cfg_high (cfg_high),
            .pend     (pend_s[i]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_divider_multi
// Directed bench for clk_divider_multi (NCH=4, CNT_W=8, defaults 12/6).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_clk_divider_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] en;
    logic       sync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_chan;
    logic [7:0] cfg_div;
    logic [7:0] cfg_high;
    logic       cfg_err;
    logic [3:0] clk_out;
    logic [3:0] tick;

    int checks = 0;
    int errors = 0;

    int bad_div  [3] = '{1, 5, 7};
    int bad_high [3] = '{1, 0, 7};

    clk_divider_multi dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic e;
        logic t;

        reset     = 1'b1;
        en        = 4'b0000;
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = 2'd0;
        cfg_div   = 8'd0;
        cfg_high  = 8'd0;
        step();
        step();

        // Reset state
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_cfg_err", 32'(cfg_err), 32'h0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'h1);

        // Channel 0 alone with defaults: 6 low, 6 high, tick on cycle 12
        reset = 1'b0;
        en    = 4'b0001;
        for (int k = 1; k <= 36; k++) begin
            e = (((k - 1) % 12) >= 6);
            t = (((k - 1) % 12) == 11);
            check("def_clk_out", 32'(clk_out), 32'({3'b000, e}));
            check("def_tick", 32'(tick), 32'({3'b000, t}));
            step();
        end

        // Reconfigure channel 1 to 5/2 in the middle of its first period
        en = 4'b0011;
        step();
        step();
        step();
        cfg_valid = 1'b1;
        cfg_chan  = 2'd1;
        cfg_div   = 8'd5;
        cfg_high  = 8'd2;
        #1;
        check("c1_ready_idle", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        #1;
        check("c1_ready_pend", 32'(cfg_ready), 32'h0);
        for (int c = 4; c <= 11; c++) begin
            check("c1_old_clk", 32'(clk_out[1]), 32'(c >= 6));
            check("c1_old_tick", 32'(tick[1]), 32'(c == 11));
            check("c1_ready_hold", 32'(cfg_ready), 32'h0);
            step();
        end
        check("c1_ready_free", 32'(cfg_ready), 32'h1);
        for (int m = 0; m < 10; m++) begin
            check("c1_new_clk", 32'(clk_out[1]), 32'((m % 5) >= 3));
            check("c1_new_tick", 32'(tick[1]), 32'((m % 5) == 4));
            step();
        end

        // Illegal requests on channel 2 are consumed and flagged
        for (int v = 0; v < 3; v++) begin
            cfg_valid = 1'b1;
            cfg_chan  = 2'd2;
            cfg_div   = 8'(bad_div[v]);
            cfg_high  = 8'(bad_high[v]);
            #1;
            check("ill_ready", 32'(cfg_ready), 32'h1);
            step();
            cfg_valid = 1'b0;
            check("ill_err_pulse", 32'(cfg_err), 32'h1);
            step();
            check("ill_err_clear", 32'(cfg_err), 32'h0);
        end
        check("ill_no_pend", 32'(cfg_ready), 32'h1);
        en = 4'b0111;
        for (int k = 0; k < 12; k++) begin
            check("ill_c2_clk", 32'(clk_out[2]), 32'(k >= 6));
            check("ill_c2_tick", 32'(tick[2]), 32'(k == 11));
            step();
        end

        // Channels 0 and 2 out of phase, then sync aligns them
        en = 4'b0100;
        step();
        step();
        step();
        en = 4'b0101;
        step();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 0; k < 24; k++) begin
            e = ((k % 12) >= 6);
            t = ((k % 12) == 11);
            check("sync_clk_out", 32'(clk_out), 32'({1'b0, e, 1'b0, e}));
            check("sync_tick", 32'(tick), 32'({1'b0, t, 1'b0, t}));
            step();
        end

        // Config for channel 0 accepted on its wrap cycle
        for (int k = 0; k < 11; k++) begin
            step();
        end
        check("wrap_tick_now", 32'(tick[0]), 32'h1);
        cfg_valid = 1'b1;
        cfg_chan  = 2'd0;
        cfg_div   = 8'd4;
        cfg_high  = 8'd1;
        #1;
        check("wrap_ready", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            e = (k >= 6);
            t = (k == 11);
            check("wrap_old_clk", 32'(clk_out), 32'({1'b0, e, 1'b0, e}));
            check("wrap_old_tick", 32'(tick), 32'({1'b0, t, 1'b0, t}));
            check("wrap_ready_hold", 32'(cfg_ready), 32'h0);
            step();
        end
        for (int m = 0; m < 8; m++) begin
            check("wrap_new_clk", 32'(clk_out[0]), 32'((m % 4) >= 3));
            check("wrap_new_tick", 32'(tick[0]), 32'((m % 4) == 3));
            step();
        end

        // Reset mid-period while channel 2 has a pending config
        cfg_valid = 1'b1;
        cfg_chan  = 2'd2;
        cfg_div   = 8'd3;
        cfg_high  = 8'd1;
        #1;
        step();
        cfg_valid = 1'b0;
        #1;
        check("rst2_pend", 32'(cfg_ready), 32'h0);
        step();
        reset = 1'b1;
        step();
        check("rst2_clk_out", 32'(clk_out), 32'h0);
        check("rst2_tick", 32'(tick), 32'h0);
        check("rst2_cfg_err", 32'(cfg_err), 32'h0);
        reset = 1'b0;
        #1;
        check("rst2_pend_clr", 32'(cfg_ready), 32'h1);
        for (int k = 0; k < 12; k++) begin
            e = (k >= 6);
            t = (k == 11);
            check("rst2_clk_out_def", 32'(clk_out), 32'({1'b0, e, 1'b0, e}));
            check("rst2_tick_def", 32'(tick), 32'({1'b0, t, 1'b0, t}));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
- NCH independent programmable clock dividers that share one runtime configuration port.
- Each channel produces a registered divided clock. The period is `div` clk cycles, and the output is high for the last `high` cycles of each period.
- Each channel also produces a one-cycle `tick` at every period wrap.
- Sits in the clock/timing area. It generates slow enables and strobes for peripherals. Configuration changes are glitch-free.

Parameters:
- NCH, 4, number of divider channels (≥1).
- CNT_W, 8, counter/config width; maximum period is 2^CNT_W-1.
- DEF_DIV, 12, period of every channel after reset (2 ≤ DEF_DIV < 2^CNT_W).
- DEF_HIGH, 6, high time of every channel after reset (1 ≤ DEF_HIGH < DEF_DIV).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  NCH  per-channel run enable.
- sync  in  1  phase-align pulse: restarts all enabled channels.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config can be accepted for cfg_chan.
- cfg_chan  in  CH_W  target channel; CH_W = max(1, clog2(NCH)).
- cfg_div  in  CNT_W  new period.
- cfg_high  in  CNT_W  new high time.
- cfg_err  out  1  one-cycle pulse: request rejected.
- clk_out  out  NCH  divided clocks (registered).
- tick  out  NCH  one-cycle pulse on each period's last cycle (registered).

Behaviour:
Per-channel state:
- cnt[CNT_W]: phase counter.
- act_div, act_high: active configuration.
- shd_div, shd_high: shadow configuration.
- pend: shadow holds an unapplied configuration.

Reset (synchronous, reset=1 at a clk edge):
- cnt=0, act_div=DEF_DIV, act_high=DEF_HIGH, pend=0.
- clk_out=0, tick=0, cfg_err=0.

Counting, enabled channel, priority reset > sync > wrap > increment:
- sync=1: cnt←0. If pend, act←shd and pend←0.
- Else, if cnt==act_div-1 (wrap): cnt←0; if pend, act←shd and pend←0.
- Else: cnt←cnt+1.

Outputs:
- clk_out registered and computed from the next-state values: each cycle clk_out == (cnt ≥ act_div-act_high) for the current cnt/act. No combinational decode reaches the output.
- tick registered so it is high exactly while cnt==act_div-1.
- Defaults: low for 6 cycles, high for 6, tick on the 12th cycle.

Disabled channel (en=0):
- Next cycle: cnt=0, clk_out=0, tick=0.
- A pending config is applied at that edge.

Enable rising:
- The first enabled cycle shows cnt=0. Counting proceeds from there; there is no partial period.

Config handshake:
- cfg_ready = !pend[cfg_chan] (combinational).
- A request is accepted when cfg_valid & cfg_ready.
- Legal request (cfg_div ≥ 2, 1 ≤ cfg_high < cfg_div, cfg_chan < NCH): shd←cfg, pend←1.
- Illegal request: no state change; cfg_err=1 on the next cycle.
- Same-cycle accept and wrap/sync/disable on the same channel: the new config goes to shadow with pend=1 and takes effect at the following wrap. The current wrap uses the old shadow state.
- An accepted config never changes act mid-period, so there are no runt pulses.

Decomposition:
- Shared package: localparam CH_W; constants DEF_DIV and DEF_HIGH; function cfg_legal(div, high).
- Natural sub-module: clk_divider_chan (one channel: cnt, act, shadow, pend, clk_out, tick). The top level holds cfg decode, ready mux, cfg_err and a generate loop over NCH.

Test Plan:
- Reset, en=4'b0001, run 36 cycles: clk_out[0] shows 0×6,1×6 three times; tick[0] high at cycles 12, 24, 36; other channels stay 0.
- Config ch1, div=5, high=2, while en[1]=1 mid-period: current 12-cycle period completes, then clk_out[1]=0,0,0,1,1 repeating. cfg_ready for chan 1 stays 0 until the wrap.
- Illegal requests (div=1; high=0; high=div=7): cfg_err pulses one cycle after each; ch behaviour unchanged (still 12/6).
- Channels 0 and 2 enabled at different times, sync pulsed: both show cnt=0 the next cycle; clk_out and tick thereafter identical.
- Config accepted on the same cycle ch0 wraps: old period repeats once more, new config applies at the following wrap.
- reset asserted mid-period with pend=1: all outputs 0 next cycle, pend cleared, defaults restored (12/6).
